// File: rtl/call_scheduler.sv
// Floor-call scheduler: debounced call buttons, request lamps, SCAN goal selection and door dwell.
// Optional SOS_HOME_EN: while sos_mode is high, send the car home to floor 1.
module call_scheduler #(
    parameter logic [1:0] labelF1         = 2'b00,
    parameter logic [1:0] labelF2         = 2'b01,
    parameter logic [1:0] labelF3         = 2'b10,
    parameter int         DEBOUNCE_CYCLES = 4,
    parameter int         DWELL_CYCLES    = 8
) (
    input  logic       clk,
    input  logic       button_reset_n,
    input  logic       button1,
    input  logic       button2,
    input  logic       button3,
    input  logic [1:0] floor,
    input  logic       moving,
    input  logic       sos_mode,
    input  logic       weight_limit_exceeded,
    output logic       led1,
    output logic       led2,
    output logic       led3,
    output logic [1:0] goal_floor,
    output logic       goal_valid,
    output logic       served,
    output logic       dir_up
);

    localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DWW = $clog2(DWELL_CYCLES + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_UP    = 2'd1;
    localparam logic [1:0] S_DOWN  = 2'd2;
    localparam logic [1:0] S_SERVE = 2'd3;

    logic [2:0]     r_s1;
    logic [2:0]     r_s2;
    logic [2:0]     r_db;
    logic [2:0]     r_dbq;
    logic [CW-1:0]  r_cnt [3];

    logic [1:0]     r_state;
    logic [2:0]     r_led;
    logic [1:0]     r_goal;
    logic           r_gv;
    logic           r_served;
    logic           r_dir;
    logic [DWW-1:0] r_dwell;
    logic           r_mq;

    logic [2:0] w_btn;
    logic [2:0] w_press;
    logic       w_fvalid;
    logic [1:0] w_fl;
    logic [2:0] w_here;
    logic       w_here_ok;
    logic [2:0] w_hp;
    logic [2:0] w_latch;
    logic       w_hold_press;
    logic       w_arrive;
    logic       w_na_v;
    logic [1:0] w_na;
    logic       w_nb_v;
    logic [1:0] w_nb;
    logic       w_ip_v;
    logic       w_ip_up;
    logic [1:0] w_ip;

    assign w_btn   = {button3, button2, button1};
    assign w_press = r_db & ~r_dbq;

    always_ff @(posedge clk or negedge button_reset_n) begin
        if (!button_reset_n) begin
            r_s1  <= '0;
            r_s2  <= '0;
            r_db  <= '0;
            r_dbq <= '0;
            for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
        end else begin
            r_s1  <= w_btn;
            r_s2  <= r_s1;
            r_dbq <= r_db;
            for (int i = 0; i < 3; i++) begin
                if (r_s2[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    r_db[i]  <= r_s2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Floor as an index 0..2; the invalid code maps to floor 1 but matches nothing.
    assign w_fvalid = (floor == labelF1) || (floor == labelF2) || (floor == labelF3);
    assign w_fl     = (floor == labelF3) ? 2'd2 : (floor == labelF2) ? 2'd1 : 2'd0;
    assign w_here   = w_fvalid ? (3'b001 << w_fl) : 3'b000;

    assign w_here_ok    = ((r_state == S_IDLE) && !moving) || (r_state == S_SERVE);
    assign w_hp         = w_press & w_here & {3{w_here_ok}};
    assign w_latch      = w_press & ~w_hp;
    assign w_hold_press = (|w_hp) && !weight_limit_exceeded;
    assign w_arrive     = (|(r_led & w_here)) && !moving &&
                          (r_mq || (r_state == S_IDLE));

    always_comb begin
        w_na_v = 1'b0;
        w_na   = 2'd0;
        w_nb_v = 1'b0;
        w_nb   = 2'd0;
        unique case (w_fl)
            2'd0: begin
                if (r_led[1]) begin
                    w_na_v = 1'b1;
                    w_na   = 2'd1;
                end else if (r_led[2]) begin
                    w_na_v = 1'b1;
                    w_na   = 2'd2;
                end
            end
            2'd1: begin
                if (r_led[2]) begin
                    w_na_v = 1'b1;
                    w_na   = 2'd2;
                end
                if (r_led[0]) begin
                    w_nb_v = 1'b1;
                    w_nb   = 2'd0;
                end
            end
            default: begin
                if (r_led[1]) begin
                    w_nb_v = 1'b1;
                    w_nb   = 2'd1;
                end else if (r_led[0]) begin
                    w_nb_v = 1'b1;
                    w_nb   = 2'd0;
                end
            end
        endcase
    end

    // Nearest pending floor; both ends are only possible from floor 2, where floor 1 wins.
    assign w_ip_v  = w_na_v || w_nb_v;
    assign w_ip_up = !w_nb_v;
    assign w_ip    = w_nb_v ? w_nb : w_na;

    always_ff @(posedge clk or negedge button_reset_n) begin
        if (!button_reset_n) begin
            r_state  <= S_IDLE;
            r_led    <= '0;
            r_goal   <= 2'd0;
            r_gv     <= 1'b0;
            r_served <= 1'b0;
            r_dir    <= 1'b1;
            r_dwell  <= '0;
            r_mq     <= 1'b0;
        end else begin
            r_mq     <= moving;
            r_served <= 1'b0;
            if (sos_mode) begin
                r_led   <= '0;
                r_state <= S_IDLE;
`ifdef SOS_HOME_EN
                r_goal  <= 2'd0;
                r_gv    <= !weight_limit_exceeded;
`else
                r_goal  <= w_fl;
                r_gv    <= 1'b0;
`endif
            end else if (w_arrive) begin
                r_led    <= (r_led | w_latch) & ~w_here;
                r_served <= 1'b1;
                r_state  <= S_SERVE;
                r_dwell  <= DWW'(DWELL_CYCLES - 1);
                r_gv     <= 1'b0;
            end else begin
                r_led <= r_led | w_latch;
                if (w_hold_press) begin
                    r_served <= (r_state == S_IDLE);
                    r_state  <= S_SERVE;
                    r_dwell  <= DWW'(DWELL_CYCLES - 1);
                    r_gv     <= 1'b0;
                end else if (weight_limit_exceeded) begin
                    r_gv <= 1'b0;
                end else begin
                    unique case (r_state)
                        S_IDLE: begin
                            if (w_ip_v) begin
                                r_goal  <= w_ip;
                                r_gv    <= 1'b1;
                                r_dir   <= w_ip_up;
                                r_state <= w_ip_up ? S_UP : S_DOWN;
                            end else begin
                                r_goal <= w_fl;
                                r_gv   <= 1'b0;
                            end
                        end
                        S_UP: begin
                            if (w_na_v) begin
                                // While travelling, only a pick-up short of the goal retargets.
                                if (!moving || (w_na < r_goal)) r_goal <= w_na;
                                r_gv <= 1'b1;
                            end else if (moving) begin
                                r_gv <= r_gv;
                            end else if (w_nb_v) begin
                                r_dir   <= 1'b0;
                                r_state <= S_DOWN;
                                r_goal  <= w_nb;
                                r_gv    <= 1'b1;
                            end else begin
                                r_state <= S_IDLE;
                                r_gv    <= 1'b0;
                            end
                        end
                        S_DOWN: begin
                            if (w_nb_v) begin
                                if (!moving || (w_nb > r_goal)) r_goal <= w_nb;
                                r_gv <= 1'b1;
                            end else if (moving) begin
                                r_gv <= r_gv;
                            end else if (w_na_v) begin
                                r_dir   <= 1'b1;
                                r_state <= S_UP;
                                r_goal  <= w_na;
                                r_gv    <= 1'b1;
                            end else begin
                                r_state <= S_IDLE;
                                r_gv    <= 1'b0;
                            end
                        end
                        default: begin
                            r_gv <= 1'b0;
                            if (r_dwell != '0) begin
                                r_dwell <= r_dwell - 1'b1;
                            end else if (r_dir && w_na_v) begin
                                r_state <= S_UP;
                                r_goal  <= w_na;
                                r_gv    <= 1'b1;
                            end else if (!r_dir && w_nb_v) begin
                                r_state <= S_DOWN;
                                r_goal  <= w_nb;
                                r_gv    <= 1'b1;
                            end else if (w_ip_v) begin
                                r_dir   <= w_ip_up;
                                r_state <= w_ip_up ? S_UP : S_DOWN;
                                r_goal  <= w_ip;
                                r_gv    <= 1'b1;
                            end else begin
                                r_state <= S_IDLE;
                                r_goal  <= w_fl;
                            end
                        end
                    endcase
                end
            end
        end
    end

    assign led1       = r_led[0];
    assign led2       = r_led[1];
    assign led3       = r_led[2];
    assign goal_floor = (r_goal == 2'd2) ? labelF3 : (r_goal == 2'd1) ? labelF2 : labelF1;
    assign goal_valid = r_gv;
    assign served     = r_served;
    assign dir_up     = r_dir;

endmodule

// File: doc/call_scheduler.md
Name: call_scheduler

Overview:
- Request-side counterpart of the elevator movement path.
- Debounces and latches the three floor call buttons and drives the request lamps.
- Selects the next goal floor with a direction-preserving (SCAN) policy and presents it to the movement logic.
- Clears each request when the car arrives and stops at that floor, then holds a door-dwell interval before issuing the next goal.

Parameters:
- labelF1, 2'b00, encoding of floor 1
- labelF2, 2'b01, encoding of floor 2
- labelF3, 2'b10, encoding of floor 3
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required to accept a button press (min 1)
- DWELL_CYCLES, 8, cycles held in SERVE after arrival before the next goal is issued (min 1)

Ports:
- clk  in  1  system clock, all state on rising edge
- button_reset_n  in  1  asynchronous active-low reset
- button1 / button2 / button3  in  1 each  raw call buttons for floors 1/2/3, asynchronous, active-high
- floor  in  2  current car floor from movement, labelF* encoding
- moving  in  1  car in motion (high while travelling)
- sos_mode  in  1  emergency mode
- weight_limit_exceeded  in  1  overload, inhibits departure
- led1 / led2 / led3  out  1 each  pending request lamp per floor
- goal_floor  out  2  requested destination
- goal_valid  out  1  goal_floor is a live request
- served  out  1  one-cycle pulse on each request completion
- dir_up  out  1  current scan direction (1 = up)

Behaviour:
- Reset (async assert, sync release):
  - led1..3 = 0, goal_floor = labelF1, goal_valid = 0, served = 0, dir_up = 1.
  - State IDLE; synchronizers and counters cleared.
- Input path, per button:
  - 2-flop synchronizer, then debounce counter.
  - Accepted press = rising edge of the debounced level, so a held button registers once.
  - First-sample to accepted-edge latency: DEBOUNCE_CYCLES+2 cycles.
- Latching an accepted press:
  - In IDLE with moving = 0 and press floor == floor: no lamp is latched; served pulses next cycle; enter SERVE.
  - In SERVE with press floor == floor: no lamp is latched; the dwell counter reloads to DWELL_CYCLES (door hold).
  - Otherwise: the corresponding led is set and stays set until served.
- Arrival:
  - Trigger: moving falls 1->0 and the led for floor is set.
  - Clear that led, pulse served, enter SERVE, goal_valid = 0.
  - A clear and a press for the same floor in the same cycle: the clear wins.
- States:
  - IDLE:
    - No pending leds: goal_valid = 0, goal_floor = floor.
    - Otherwise pick the nearest pending floor. From labelF2 with both ends pending, prefer labelF1.
    - Set dir_up toward the target; enter UP or DOWN.
  - UP:
    - goal = nearest pending floor above floor; goal_valid = 1.
    - None above but some below: dir_up = 0, go to DOWN. No pending leds: go to IDLE.
  - DOWN: mirror of UP.
  - SERVE:
    - Decrement the dwell counter each cycle; goal_valid = 0.
    - At 0: resume UP/DOWN per dir_up if any led is pending in that direction, else re-evaluate as IDLE.
- Goal stability: goal_floor changes only when moving = 0 or when a newly latched request lies strictly between floor and the current goal in the travel direction (pick-up on the way).
- weight_limit_exceeded high:
  - goal_valid forced 0; state and dwell counter frozen.
  - Presses are still latched.
  - On release, the scheduler resumes from the frozen state.
- sos_mode high:
  - All leds cleared; state forced to IDLE; presses ignored; served held 0.
  - goal_valid behaviour is set by the optional feature below.
- Reset mid-operation: everything returns to reset values immediately; pending requests are discarded.
- Floor value 2'b11 is invalid: treated as labelF1 for distance computation, no latching side effects.

Optional Feature:
- Macro: SOS_HOME_EN.
- Defined: while sos_mode is high, goal_floor = labelF1 and goal_valid = 1, unless weight_limit_exceeded is high. After sos_mode falls, the block resumes from IDLE.
- Undefined: while sos_mode is high, goal_valid = 0 and goal_floor = floor.

Test Plan:
1. Reset pulse with all buttons held high -> after release, led1..3 = 0, goal_valid = 0. After DEBOUNCE_CYCLES+2 cycles, led2 = 1 and led3 = 1; led1 stays 0 and served pulses (floor = labelF1, idle press at current floor).
2. floor = labelF1, led3 set, then press button2 while moving = 1 and floor still labelF1 -> goal_floor switches 2'b10 -> 2'b01. On moving falling at floor = 2'b01: led2 clears, served pulses once, goal_valid = 0 for exactly DWELL_CYCLES = 8 cycles, then goal_floor = 2'b10.
3. floor = labelF2 idle, button1 and button3 accepted the same cycle -> goal_floor = 2'b00, dir_up = 0. After arrival and dwell, goal_floor = 2'b10, dir_up = 1.
4. In SERVE at labelF2, press button2 at dwell count 3 -> counter reloads, goal_valid stays 0 for 8 more cycles, no led2.
5. weight_limit_exceeded = 1 with led3 pending -> goal_valid = 0, press button1 still sets led1. Deassert -> goal_valid = 1 within 1 cycle, SCAN order preserved.
6. sos_mode = 1 with led1 and led3 pending -> leds clear next cycle, presses ignored. With SOS_HOME_EN: goal_floor = 2'b00, goal_valid = 1. Without: goal_valid = 0.
